// File: rtl/flt_mc_fir_if.sv
// flt_mc_fir_if: coefficient write port, sample input handshake and
// filtered output bundle for flt_mc_fir. The master drives coefficients
// and samples. The slave (the filter) answers with ready and results.
interface flt_mc_fir_if #(
  parameter int IN_WIDTH   = 24,
  parameter int OUT_WIDTH  = 24,
  parameter int COF_WIDTH  = 16,
  parameter int ADDR_WIDTH = 5,
  parameter int CH_W       = 1
);
  logic                         WrEn_SI;
  logic [ADDR_WIDTH-1:0]        Addr_DI;
  logic signed [COF_WIDTH-1:0]  PAR_In_DI;
  logic                         In_Valid_SI;
  logic [CH_W-1:0]              In_Ch_DI;
  logic signed [IN_WIDTH-1:0]   FLT_In_DI;
  logic                         In_Ready_SO;
  logic                         Out_Valid_SO;
  logic [CH_W-1:0]              Out_Ch_DO;
  logic signed [OUT_WIDTH-1:0]  FLT_Out_DO;

  modport master (
    output WrEn_SI, Addr_DI, PAR_In_DI, In_Valid_SI, In_Ch_DI, FLT_In_DI,
    input  In_Ready_SO, Out_Valid_SO, Out_Ch_DO, FLT_Out_DO
  );

  modport slave (
    input  WrEn_SI, Addr_DI, PAR_In_DI, In_Valid_SI, In_Ch_DI, FLT_In_DI,
    output In_Ready_SO, Out_Valid_SO, Out_Ch_DO, FLT_Out_DO
  );
endinterface

// File: rtl/flt_mc_fir.sv
// flt_mc_fir: multi-channel, time-multiplexed FIR filter. One shared MAC
// walks NUM_TAPS taps of the selected channel per accepted sample. The
// result is rounded, reduced to OUT_WIDTH and emitted with a one-cycle strobe.
// Optional macro FLT_SAT_EN: when defined, the output saturates to the
// OUT_WIDTH range. Otherwise it wraps (keeps the low OUT_WIDTH bits).
module flt_mc_fir #(
  parameter int IN_WIDTH   = 24,
  parameter int OUT_WIDTH  = 24,
  parameter int COF_WIDTH  = 16,
  parameter int FRAC_BITS  = 14,
  parameter int NUM_TAPS   = 8,
  parameter int NUM_CH     = 2,
  parameter int ADDR_WIDTH = 5
) (
  input logic         Clk_CI,
  input logic         Rst_RI,
  flt_mc_fir_if.slave bus
);

  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TAP_W    = $clog2(NUM_TAPS);
  localparam int NUM_COEF = NUM_CH * NUM_TAPS;
  localparam int PROD_W   = IN_WIDTH + COF_WIDTH;
  localparam int ACC_W    = PROD_W + TAP_W;
  localparam int R_W      = ACC_W - FRAC_BITS;
  localparam logic signed [ACC_W-1:0] RND = ACC_W'(1) << (FRAC_BITS - 1);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

  state_t                       state_q, state_d;
  logic [CH_W-1:0]              ch_q, ch_d;
  logic [TAP_W-1:0]             k_q, k_d;
  logic signed [ACC_W-1:0]      acc_q, acc_d;
  logic signed [OUT_WIDTH-1:0]  out_q, out_d;
  logic [CH_W-1:0]              out_ch_q, out_ch_d;
  logic                         out_valid_q, out_valid_d;

  logic signed [COF_WIDTH-1:0]  coef_q [NUM_CH][NUM_TAPS];
  logic signed [COF_WIDTH-1:0]  coef_d [NUM_CH][NUM_TAPS];
  logic signed [IN_WIDTH-1:0]   x_q    [NUM_CH][NUM_TAPS];
  logic signed [IN_WIDTH-1:0]   x_d    [NUM_CH][NUM_TAPS];

  logic                         accept;
  logic                         ch_ok;
  logic [NUM_COEF-1:0]          wr_hit;
  logic [NUM_CH-1:0]            shift_en;
  logic signed [COF_WIDTH-1:0]  coef_rd;
  logic signed [IN_WIDTH-1:0]   x_rd;
  logic signed [PROD_W-1:0]     prod;
  logic signed [ACC_W-1:0]      rnd_sum;
  logic signed [R_W-1:0]        r;
  logic signed [OUT_WIDTH-1:0]  out_res;
  logic                         unused_bits;

  assign accept = bus.In_Valid_SI && (state_q == S_IDLE);
  assign ch_ok  = (32'(bus.In_Ch_DI) < NUM_CH);

  // Per-address write strobes; addresses beyond the last coefficient match nothing.
  for (genvar gi = 0; gi < NUM_COEF; gi++) begin : g_wr_hit
    assign wr_hit[gi] = bus.WrEn_SI && (bus.Addr_DI == ADDR_WIDTH'(gi));
  end

  // Per-channel shift enables: only the addressed channel's delay line moves.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_shift_en
    assign shift_en[gi] = accept && ch_ok && (bus.In_Ch_DI == CH_W'(gi));
  end

  // Product of the current tap. The coefficient is read from the registered
  // array, so a write landing on the same edge is seen only by later taps.
  assign prod    = PROD_W'(coef_rd) * PROD_W'(x_rd);
  assign rnd_sum = acc_q + RND;
  assign r       = rnd_sum[ACC_W-1:FRAC_BITS];

`ifdef FLT_SAT_EN
  localparam logic signed [R_W-1:0] R_MAX = R_W'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
  localparam logic signed [R_W-1:0] R_MIN = R_W'(-(64'sd1 <<< (OUT_WIDTH - 1)));
  assign out_res = (r > R_MAX) ? R_MAX[OUT_WIDTH-1:0] :
                   (r < R_MIN) ? R_MIN[OUT_WIDTH-1:0] : r[OUT_WIDTH-1:0];
  assign unused_bits = ^rnd_sum[FRAC_BITS-1:0];
`else
  assign out_res = r[OUT_WIDTH-1:0];
  assign unused_bits = ^{rnd_sum[FRAC_BITS-1:0], r[R_W-1:OUT_WIDTH]};
`endif

  // Next-state logic: coefficient writes, delay-line shifts, tap mux and FSM.
  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    k_d         = k_q;
    acc_d       = acc_q;
    out_d       = out_q;
    out_ch_d    = out_ch_q;
    out_valid_d = 1'b0;
    coef_rd     = '0;
    x_rd        = '0;

    for (int c = 0; c < NUM_CH; c++) begin
      for (int t = 0; t < NUM_TAPS; t++) begin
        coef_d[c][t] = wr_hit[c*NUM_TAPS + t] ? bus.PAR_In_DI : coef_q[c][t];
        x_d[c][t]    = x_q[c][t];
        if (ch_q == CH_W'(c) && k_q == TAP_W'(t)) begin
          coef_rd = coef_q[c][t];
          x_rd    = x_q[c][t];
        end
      end
      if (shift_en[c]) begin
        x_d[c][0] = bus.FLT_In_DI;
        for (int t = 1; t < NUM_TAPS; t++) begin
          x_d[c][t] = x_q[c][t-1];
        end
      end
    end

    case (state_q)
      S_IDLE: begin
        // Samples tagged with a nonexistent channel are consumed and dropped.
        if (accept && ch_ok) begin
          ch_d    = bus.In_Ch_DI;
          k_d     = '0;
          acc_d   = '0;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        acc_d = acc_q + ACC_W'(prod);
        k_d   = k_q + TAP_W'(1);
        if (k_q == TAP_W'(NUM_TAPS - 1)) begin
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        out_d       = out_res;
        out_ch_d    = ch_q;
        out_valid_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers. Reset aborts any computation and clears all storage.
  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      state_q     <= S_IDLE;
      ch_q        <= '0;
      k_q         <= '0;
      acc_q       <= '0;
      out_q       <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        for (int t = 0; t < NUM_TAPS; t++) begin
          coef_q[c][t] <= '0;
          x_q[c][t]    <= '0;
        end
      end
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      out_q       <= out_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      coef_q      <= coef_d;
      x_q         <= x_d;
    end
  end

  assign bus.In_Ready_SO  = (state_q == S_IDLE);
  assign bus.Out_Valid_SO = out_valid_q;
  assign bus.Out_Ch_DO    = out_ch_q;
  assign bus.FLT_Out_DO   = out_q;

endmodule

// File: tb/tb_flt_mc_fir.sv
// tb_flt_mc_fir: directed bench for flt_mc_fir at default parameters, plus a
// three-channel instance to exercise dropping of out-of-range channel IDs.
// Inputs change and outputs are sampled on the falling clock edge.
`timescale 1ns/1ps
module tb_flt_mc_fir;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

`ifdef FLT_SAT_EN
  localparam int EXP_OVF = 8388607;
`else
  localparam int EXP_OVF = -514;
`endif

  flt_mc_fir_if #(.IN_WIDTH(24), .OUT_WIDTH(24), .COF_WIDTH(16), .ADDR_WIDTH(5), .CH_W(1)) bus1 ();
  flt_mc_fir_if #(.IN_WIDTH(24), .OUT_WIDTH(24), .COF_WIDTH(16), .ADDR_WIDTH(5), .CH_W(2)) bus3 ();

  flt_mc_fir #(.IN_WIDTH(24), .OUT_WIDTH(24), .COF_WIDTH(16), .FRAC_BITS(14),
               .NUM_TAPS(8), .NUM_CH(2), .ADDR_WIDTH(5)) dut (
    .Clk_CI (clk),
    .Rst_RI (rst),
    .bus    (bus1)
  );

  flt_mc_fir #(.IN_WIDTH(24), .OUT_WIDTH(24), .COF_WIDTH(16), .FRAC_BITS(14),
               .NUM_TAPS(8), .NUM_CH(3), .ADDR_WIDTH(5)) dut3 (
    .Clk_CI (clk),
    .Rst_RI (rst),
    .bus    (bus3)
  );

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Reset both instances; starts and ends on a falling edge.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic write_coef(input int addr, input logic signed [15:0] val);
    bus1.WrEn_SI   = 1'b1;
    bus1.Addr_DI   = 5'(addr);
    bus1.PAR_In_DI = val;
    @(negedge clk);
    bus1.WrEn_SI   = 1'b0;
    $display("write coef[%0d] = %0d", addr, val);
  endtask

  // Offer one sample in an idle cycle and check the full output timeline.
  task automatic run_sample(input string tag, input int ch,
                            input logic signed [23:0] data, input int exp_out);
    logic early;
    logic busy;
    check($sformatf("%s ready", tag), bus1.In_Ready_SO, 1);
    bus1.In_Valid_SI = 1'b1;
    bus1.In_Ch_DI    = 1'(ch);
    bus1.FLT_In_DI   = data;
    @(negedge clk);
    bus1.In_Valid_SI = 1'b0;
    early = 1'b0;
    busy  = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      if (i > 1) @(negedge clk);
      if (i <= 9) begin
        early = early | bus1.Out_Valid_SO;
        busy  = busy | bus1.In_Ready_SO;
      end
    end
    check($sformatf("%s early valid", tag), early, 0);
    check($sformatf("%s ready low", tag), busy, 0);
    check($sformatf("%s valid", tag), bus1.Out_Valid_SO, 1);
    check($sformatf("%s ready back", tag), bus1.In_Ready_SO, 1);
    check($sformatf("%s data", tag), bus1.FLT_Out_DO, exp_out);
    check($sformatf("%s ch", tag), bus1.Out_Ch_DO, ch);
    $display("%s: ch%0d in=%0d -> out=%0d ch=%0d (expect %0d)",
             tag, ch, data, bus1.FLT_Out_DO, bus1.Out_Ch_DO, exp_out);
    @(negedge clk);
    check($sformatf("%s pulse end", tag), bus1.Out_Valid_SO, 0);
  endtask

  initial begin
    int   bad_rdy;
    int   bad_val;
    logic seen;

    rst = 1'b1;
    bus1.WrEn_SI = 1'b0; bus1.Addr_DI = '0; bus1.PAR_In_DI = '0;
    bus1.In_Valid_SI = 1'b0; bus1.In_Ch_DI = '0; bus1.FLT_In_DI = '0;
    bus3.WrEn_SI = 1'b0; bus3.Addr_DI = '0; bus3.PAR_In_DI = '0;
    bus3.In_Valid_SI = 1'b0; bus3.In_Ch_DI = '0; bus3.FLT_In_DI = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst ready", bus1.In_Ready_SO, 1);
    check("rst valid", bus1.Out_Valid_SO, 0);
    check("rst out", bus1.FLT_Out_DO, 0);
    check("rst ch", bus1.Out_Ch_DO, 0);
    $display("reset: ready=%0d valid=%0d out=%0d", bus1.In_Ready_SO, bus1.Out_Valid_SO, bus1.FLT_Out_DO);

    // Zero coefficients
    run_sample("zero", 0, 24'sd1000, 0);

    // Delay tap at k=3; write to address 19 must not alias onto it
    do_reset();
    write_coef(3, 16'sd16384);
    write_coef(19, 16'sd5000);
    run_sample("tap s0", 0, 24'sd1000, 0);
    run_sample("tap s1", 0, 24'sd0, 0);
    run_sample("tap s2", 0, 24'sd0, 0);
    run_sample("tap s3", 0, 24'sd0, 1000);

    // Channel isolation and output hold
    do_reset();
    write_coef(0, 16'sd16384);
    write_coef(8, -16'sd8192);
    run_sample("iso ch0", 0, 24'sd400, 400);
    run_sample("iso ch1", 1, 24'sd400, -200);
    repeat (3) @(negedge clk);
    check("hold data", bus1.FLT_Out_DO, -200);
    check("hold ch", bus1.Out_Ch_DO, 1);
    run_sample("iso ch0 zero", 0, 24'sd0, 0);

    // Overflow of the rounded result
    do_reset();
    write_coef(0, 16'sd32767);
    run_sample("ovf", 0, 24'sd8388607, EXP_OVF);

    // Handshake with valid held high and data changing every cycle
    do_reset();
    write_coef(0, 16'sd16384);
    bad_rdy = 0;
    bad_val = 0;
    for (int c = 0; c <= 30; c++) begin
      if (c > 0) @(negedge clk);
      if (bus1.In_Ready_SO !== (c % 10 == 0)) bad_rdy++;
      if (bus1.Out_Valid_SO !== (c > 0 && c % 10 == 0)) bad_val++;
      if (c > 0 && c % 10 == 0) begin
        check($sformatf("hs out %0d", c / 10), bus1.FLT_Out_DO, 10 * (c - 10) + 10);
        $display("hs cycle %0d: out=%0d", c, bus1.FLT_Out_DO);
      end
      bus1.In_Valid_SI = (c < 30);
      bus1.In_Ch_DI    = 1'b0;
      bus1.FLT_In_DI   = 24'(10 * c + 10);
    end
    bus1.In_Valid_SI = 1'b0;
    check("hs ready pattern", bad_rdy, 0);
    check("hs valid pattern", bad_val, 0);

    // Out-of-range channel on the three-channel instance is dropped
    bus3.In_Valid_SI = 1'b1;
    bus3.In_Ch_DI    = 2'd3;
    bus3.FLT_In_DI   = 24'sd777;
    @(negedge clk);
    bus3.In_Valid_SI = 1'b0;
    check("drop ready", bus3.In_Ready_SO, 1);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      seen = seen | bus3.Out_Valid_SO;
    end
    check("drop no output", seen, 0);
    $display("drop ch3: output seen=%0d", seen);
    bus3.In_Valid_SI = 1'b1;
    bus3.In_Ch_DI    = 2'd2;
    bus3.FLT_In_DI   = 24'sd5;
    @(negedge clk);
    bus3.In_Valid_SI = 1'b0;
    repeat (9) @(negedge clk);
    check("ch2 valid", bus3.Out_Valid_SO, 1);
    check("ch2 ch", bus3.Out_Ch_DO, 2);
    $display("ch2 sample: valid=%0d ch=%0d out=%0d", bus3.Out_Valid_SO, bus3.Out_Ch_DO, bus3.FLT_Out_DO);
    @(negedge clk);

    // Reset asserted during MAC cycle 3 of a sample
    do_reset();
    write_coef(0, 16'sd16384);
    write_coef(8, 16'sd16384);
    run_sample("pre ch1", 1, 24'sd700, 700);
    bus1.In_Valid_SI = 1'b1;
    bus1.In_Ch_DI    = 1'b0;
    bus1.FLT_In_DI   = 24'sd5000;
    @(negedge clk);
    bus1.In_Valid_SI = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst valid", bus1.Out_Valid_SO, 0);
    check("midrst out", bus1.FLT_Out_DO, 0);
    check("midrst ch", bus1.Out_Ch_DO, 0);
    check("midrst ready", bus1.In_Ready_SO, 1);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      seen = seen | bus1.Out_Valid_SO;
    end
    check("midrst no output", seen, 0);
    $display("reset mid-MAC: output seen=%0d", seen);
    run_sample("post ch1", 1, 24'sd700, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
